// File: rtl/acc_button_sequencer_pkg.sv
// Shared types and default parameters for the push-button command sequencer.
// Holds the FSM state encoding and the locked-button select codes.
package acc_button_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_PLUS  = 2'd1,
    SEL_MINUS = 2'd2
  } sel_e;

  localparam int DEF_HOLD_TICKS   = 8;
  localparam int DEF_REPEAT_TICKS = 2;
  localparam int DEF_CNT_W        = 4;

endpackage

// File: rtl/acc_button_sequencer_if.sv
// Button levels and tick in, registered command strobes and active flag out.
// Plain levels and one-cycle strobes; no handshake and no backpressure.
interface acc_button_sequencer_if;
  logic tick;
  logic btn_plus;
  logic btn_minus;
  logic btn_clear;
  logic cmd_inc;
  logic cmd_dec;
  logic cmd_clr;
  logic active;

  modport master (
    output tick, btn_plus, btn_minus, btn_clear,
    input  cmd_inc, cmd_dec, cmd_clr, active
  );

  modport slave (
    input  tick, btn_plus, btn_minus, btn_clear,
    output cmd_inc, cmd_dec, cmd_clr, active
  );
endinterface

// File: rtl/acc_button_sequencer_tick_counter.sv
// Tick counter with clear/enable; hit_o flags the tick that would reach thresh_i.
// hit_o is combinational from the registered count; no backpressure.
module tick_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit so the compare never aliases on an all-ones threshold.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign hit_o   = tick_i && (cnt_inc == {1'b0, thresh_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && tick_i) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_button_sequencer.sv
// Turns button levels into inc/dec/clr strobes with clear>plus>minus arbitration and auto-repeat.
// Strobes appear one clk after the deciding sample; levels only, no backpressure.
module acc_button_sequencer
  import acc_button_sequencer_pkg::*;
#(
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  acc_button_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_TH   = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] REPEAT_TH = CNT_W'(REPEAT_TICKS);

  state_e state_q, state_d;
  sel_e   sel_q, sel_d;
  logic   inc_q, inc_d;
  logic   dec_q, dec_d;
  logic   clr_q, clr_d;
  logic   active_q;

  logic             cnt_clr;
  logic             cnt_en;
  logic             hit;
  logic [CNT_W-1:0] thresh;
  logic             locked;
  logic             any_btn;

  assign any_btn = bus.btn_plus || bus.btn_minus || bus.btn_clear;
  assign locked  = (sel_q == SEL_PLUS)  ? bus.btn_plus  :
                   (sel_q == SEL_MINUS) ? bus.btn_minus : 1'b0;
  assign thresh  = (state_q == REPEAT) ? REPEAT_TH : HOLD_TH;

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tick_i   (bus.tick),
    .thresh_i (thresh),
    .hit_o    (hit)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    clr_d   = 1'b0;
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = SEL_NONE;
        if (bus.btn_clear) begin
          clr_d   = 1'b1;
          state_d = WAIT_REL;
        end else if (bus.btn_plus) begin
          inc_d   = 1'b1;
          sel_d   = SEL_PLUS;
          state_d = HOLD;
        end else if (bus.btn_minus) begin
          dec_d   = 1'b1;
          sel_d   = SEL_MINUS;
          state_d = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // Clear can only be high here if it rose after the lock was taken.
        if (bus.btn_clear) begin
          clr_d   = 1'b1;
          sel_d   = SEL_NONE;
          state_d = WAIT_REL;
        end else if (!locked) begin
          sel_d   = SEL_NONE;
          state_d = any_btn ? WAIT_REL : IDLE;
        end else begin
          cnt_en  = 1'b1;
          cnt_clr = hit;
          if (hit) begin
            inc_d   = (sel_q == SEL_PLUS);
            dec_d   = (sel_q == SEL_MINUS);
            state_d = REPEAT;
          end
        end
      end
      WAIT_REL: begin
        if (!any_btn) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= SEL_NONE;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      clr_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      clr_q    <= clr_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign bus.cmd_inc = inc_q;
  assign bus.cmd_dec = dec_q;
  assign bus.cmd_clr = clr_q;
  assign bus.active  = active_q;

endmodule

// File: tb/tb_acc_button_sequencer.sv
// Directed scenarios push expected strobes (kind, cycle) into a queue; a negedge monitor checks them.
module tb_acc_button_sequencer;
  import acc_button_sequencer_pkg::*;

  localparam logic [1:0] K_INC = 2'd1;
  localparam logic [1:0] K_DEC = 2'd2;
  localparam logic [1:0] K_CLR = 2'd3;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  acc_button_sequencer_if bus();

  acc_button_sequencer #(
    .HOLD_TICKS   (8),
    .REPEAT_TICKS (2),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the queue in kind and cycle.
  always @(negedge clk) begin
    int         n;
    logic [1:0] k;
    exp_t       e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_strobe got none exp kind %0d at cyc %0d (now %0d)", sb[0].kind, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    n = int'(bus.cmd_inc === 1'b1) + int'(bus.cmd_dec === 1'b1) + int'(bus.cmd_clr === 1'b1);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL onehot got inc=%b dec=%b clr=%b exp at most one at cyc %0d",
               bus.cmd_inc, bus.cmd_dec, bus.cmd_clr, cyc);
    end else if (n == 1) begin
      k = (bus.cmd_inc === 1'b1) ? K_INC : (bus.cmd_dec === 1'b1) ? K_DEC : K_CLR;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got kind %0d at cyc %0d exp none", k, cyc);
      end else begin
        e = sb.pop_front();
        if (e.kind != k || e.cyc != cyc) begin
          errors++;
          $display("FAIL strobe got kind %0d at cyc %0d exp kind %0d at cyc %0d", k, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  // Expect a strobe from the sample taken at the next clock edge.
  task automatic expect_next(input logic [1:0] kind);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic apply(input logic p, input logic m, input logic c, input logic t);
    bus.btn_plus  = p;
    bus.btn_minus = m;
    bus.btn_clear = c;
    bus.tick      = t;
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input logic p, input logic m, input logic c);
    apply(p, m, c, 1'b1);
    apply(p, m, c, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.btn_plus  = 1'b1;
    bus.btn_minus = 1'b1;
    bus.btn_clear = 1'b1;
    bus.tick      = 1'b0;

    // Reset with every button pressed.
    @(posedge clk);
    #1;
    chk("reset_inc", bus.cmd_inc, 1'b0);
    chk("reset_dec", bus.cmd_dec, 1'b0);
    chk("reset_clr", bus.cmd_clr, 1'b0);
    chk("reset_active", bus.active, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_active", bus.active, 1'b0);

    // Single tap.
    expect_next(K_INC);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tap_active", bus.active, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("tap_idle", bus.active, 1'b0);
    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0);

    // Hold minus: release lands on the 20th tick, which would have been a repeat.
    expect_next(K_DEC);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) begin
        apply(1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        if (k >= 8 && (k % 2) == 0) expect_next(K_DEC);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    chk("hold_release_idle", bus.active, 1'b0);
    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0);

    // Release on the threshold tick.
    expect_next(K_INC);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) tk(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    chk("thresh_release_idle", bus.active, 1'b0);
    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0);

    // All three at once, then plus and minus together.
    expect_next(K_CLR);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    chk("simul_active", bus.active, 1'b1);
    repeat (3) tk(1'b1, 1'b1, 1'b1);
    repeat (10) tk(1'b1, 1'b1, 1'b0);
    chk("simul_wait", bus.active, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("simul_idle", bus.active, 1'b0);
    expect_next(K_INC);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) tk(1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pm_idle", bus.active, 1'b0);
    repeat (2) apply(1'b0, 1'b0, 1'b0, 1'b0);

    // Clear preempts a repeating plus; plus must be re-pressed afterwards.
    expect_next(K_INC);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 8) expect_next(K_INC);
      tk(1'b1, 1'b0, 1'b0);
    end
    expect_next(K_CLR);
    apply(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) tk(1'b1, 1'b0, 1'b1);
    repeat (10) tk(1'b1, 1'b0, 1'b0);
    chk("preempt_wait", bus.active, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("preempt_idle", bus.active, 1'b0);
    expect_next(K_INC);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) apply(1'b0, 1'b0, 1'b0, 1'b0);

    // Cross-button: minus pressed under a plus lock, plus released first.
    expect_next(K_INC);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tk(1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) tk(1'b0, 1'b1, 1'b0);
    chk("cross_wait", bus.active, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("cross_idle", bus.active, 1'b0);
    repeat (4) apply(1'b0, 1'b0, 1'b0, 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
